// File: rtl/alu_pipe_pkg.sv
// Shared opcodes, FSM states and flag bundle for alu_pipe.
// ALU_PIPE_MUL_EN adds the MUL state used by the optional multiplier.
package alu_pipe_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_CMP = 4'd7;
    localparam logic [3:0] OP_ADC = 4'd8;
    localparam logic [3:0] OP_SBB = 4'd9;
    localparam logic [3:0] OP_ASR = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    localparam logic [1:0] SH_LEFT  = 2'd0;
    localparam logic [1:0] SH_RIGHT = 2'd1;
    localparam logic [1:0] SH_ARITH = 2'd2;

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_MUL   = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;
`endif

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic negative;
    } flags_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
    endfunction

    function automatic logic [1:0] shift_mode(input logic [3:0] op);
        case (op)
            OP_SHL:  return SH_LEFT;
            OP_ASR:  return SH_ARITH;
            default: return SH_RIGHT;
        endcase
    endfunction

endpackage

// File: rtl/alu_pipe_shift.sv
// Iterative one-bit-per-cycle shifter: load latches operand and amount,
// each step shifts once, done flags the step that produces the final value.
module alu_pipe_shift
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   amount_i,
    output logic [WIDTH-1:0] data_o,
    output logic             bit_o,
    output logic             done_o
);

    logic [WIDTH-1:0] data_q;
    logic [1:0]       mode_q;
    logic [SHW-1:0]   cnt_q;

    // data_o/bit_o are the result of the step taken at the next edge.
    always_comb begin
        case (mode_q)
            SH_LEFT: begin
                data_o = {data_q[WIDTH-2:0], 1'b0};
                bit_o  = data_q[WIDTH-1];
            end
            SH_ARITH: begin
                data_o = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                bit_o  = data_q[0];
            end
            default: begin
                data_o = {1'b0, data_q[WIDTH-1:1]};
                bit_o  = data_q[0];
            end
        endcase
    end

    assign done_o = step_i && (cnt_q == SHW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            mode_q <= SH_LEFT;
            cnt_q  <= '0;
        end else if (load_i) begin
            data_q <= data_i;
            mode_q <= mode_i;
            cnt_q  <= amount_i;
        end else if (step_i) begin
            data_q <= data_o;
            cnt_q  <= cnt_q - SHW'(1);
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Valid/ready ALU with single-cycle arithmetic/logic, iterative shifts and,
// when ALU_PIPE_MUL_EN is defined, an iterative shift-add multiplier.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;
    logic             cin_q, cin_d;

    logic             xfer;
    logic             drain;
    logic             start_shift;
    logic [SHW-1:0]   amount;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] alu_res;
    flags_t           alu_flags;
    logic             alu_upd_c;

    logic [WIDTH-1:0] sh_next;
    logic             sh_bit;
    logic             sh_done;

    assign amount      = b[SHW-1:0];
    assign in_ready    = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign xfer        = in_valid && in_ready;
    assign drain       = out_valid_q && out_ready;
    assign start_shift = is_shift_op(opcode) && (amount != '0);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        alu_upd_c = 1'b0;
        sum_w     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (opcode == OP_ADC) && cin_q};
        diff_w    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (opcode == OP_SBB) && cin_q};
        case (opcode)
            OP_ADD, OP_ADC: begin
                alu_res            = sum_w[WIDTH-1:0];
                alu_flags.carry    = sum_w[WIDTH];
                alu_flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
                alu_upd_c          = 1'b1;
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                alu_res            = diff_w[WIDTH-1:0];
                alu_flags.carry    = diff_w[WIDTH];
                alu_flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] == b[WIDTH-1]);
                alu_upd_c          = 1'b1;
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            // Zero-amount shifts only; nonzero amounts go through the shifter.
            OP_SHL, OP_SHR, OP_ASR: begin
                alu_res   = a;
                alu_upd_c = 1'b1;
            end
            default: ;
        endcase
        alu_flags.zero     = (alu_res == '0);
        alu_flags.negative = alu_res[WIDTH-1];
    end

    alu_pipe_shift #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load_i   (xfer && start_shift),
        .step_i   (state_q == ST_SHIFT),
        .mode_i   (shift_mode(opcode)),
        .data_i   (a),
        .amount_i (amount),
        .data_o   (sh_next),
        .bit_o    (sh_bit),
        .done_o   (sh_done)
    );

`ifdef ALU_PIPE_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [CW-1:0]      mcnt_q;
    logic [WIDTH:0]     macc;
    logic               mul_done;

    // {hi, lo} starts as {0, b}; each step adds a into hi on lo[0] and shifts right.
    assign macc     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_d   = {macc, prod_q[WIDTH-1:1]};
    assign mul_done = (state_q == ST_MUL) && (mcnt_q == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q  <= '0;
            mcand_q <= '0;
            mcnt_q  <= '0;
        end else if (xfer && (opcode == OP_MUL)) begin
            prod_q  <= {{WIDTH{1'b0}}, b};
            mcand_q <= a;
            mcnt_q  <= CW'(WIDTH);
        end else if (state_q == ST_MUL) begin
            prod_q  <= prod_d;
            mcnt_q  <= mcnt_q - CW'(1);
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        cin_d       = cin_q;
        case (state_q)
            ST_IDLE: begin
                if (drain) out_valid_d = 1'b0;
                if (xfer) begin
                    if (start_shift) begin
                        state_d = ST_SHIFT;
`ifdef ALU_PIPE_MUL_EN
                    end else if (opcode == OP_MUL) begin
                        state_d = ST_MUL;
`endif
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        flags_d     = alu_flags;
                        if (alu_upd_c) cin_d = alu_flags.carry;
                    end
                end else if (out_valid_q && !out_ready) begin
                    state_d = ST_HOLD;
                end
            end
            ST_SHIFT: begin
                if (sh_done) begin
                    state_d          = ST_IDLE;
                    out_valid_d      = 1'b1;
                    result_d         = sh_next;
                    flags_d.zero     = (sh_next == '0);
                    flags_d.carry    = sh_bit;
                    flags_d.overflow = 1'b0;
                    flags_d.negative = sh_next[WIDTH-1];
                    cin_d            = sh_bit;
                end
            end
`ifdef ALU_PIPE_MUL_EN
            ST_MUL: begin
                if (mul_done) begin
                    state_d          = ST_IDLE;
                    out_valid_d      = 1'b1;
                    result_d         = prod_d[WIDTH-1:0];
                    flags_d.zero     = (prod_d[WIDTH-1:0] == '0);
                    flags_d.carry    = |prod_d[2*WIDTH-1:WIDTH];
                    flags_d.overflow = |prod_d[2*WIDTH-1:WIDTH];
                    flags_d.negative = prod_d[WIDTH-1];
                    cin_d            = |prod_d[2*WIDTH-1:WIDTH];
                end
            end
`endif
            ST_HOLD: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            cin_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            cin_q       <= cin_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = flags_q.zero;
    assign carry     = flags_q.carry;
    assign overflow  = flags_q.overflow;
    assign negative  = flags_q.negative;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=16); builds with or without ALU_PIPE_MUL_EN.
module tb_alu_pipe;

    localparam int WIDTH = 16;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_CMP = 4'd7;
    localparam logic [3:0] OP_ADC = 4'd8;
    localparam logic [3:0] OP_SBB = 4'd9;
    localparam logic [3:0] OP_ASR = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    typedef struct packed {
        logic [15:0] res;
        logic        z;
        logic        c;
        logic        v;
        logic        n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [3:0]  opcode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        zero, carry, overflow, negative;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    logic model_c = 1'b0;
    bit   rand_rdy = 1'b0;
    int   cyc = 0;

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic exp_t model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                                   input logic ci);
        exp_t        e;
        logic [16:0] w;
        logic [31:0] p;
        int          n;
        e = '0;
        p = '0;
        case (op)
            OP_ADD, OP_ADC: begin
                w     = {1'b0, x} + {1'b0, y} + 17'((op == OP_ADC) ? ci : 1'b0);
                e.res = w[15:0];
                e.c   = w[16];
                e.v   = (x[15] == y[15]) && (w[15] != x[15]);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                w     = {1'b0, x} - {1'b0, y} - 17'((op == OP_SBB) ? ci : 1'b0);
                e.res = w[15:0];
                e.c   = w[16];
                e.v   = (x[15] != y[15]) && (w[15] == y[15]);
            end
            OP_AND: e.res = x & y;
            OP_OR:  e.res = x | y;
            OP_XOR: e.res = x ^ y;
            OP_SHL, OP_SHR, OP_ASR: begin
                e.res = x;
                n = int'(y[3:0]);
                for (int i = 0; i < n; i++) begin
                    if (op == OP_SHL) begin
                        e.c   = e.res[15];
                        e.res = e.res << 1;
                    end else begin
                        e.c   = e.res[0];
                        e.res = (op == OP_ASR) ? {e.res[15], e.res[15:1]} : (e.res >> 1);
                    end
                end
            end
`ifdef ALU_PIPE_MUL_EN
            OP_MUL: begin
                p     = 32'(x) * 32'(y);
                e.res = p[15:0];
                e.c   = (p[31:16] != 0);
                e.v   = (p[31:16] != 0);
            end
`endif
            default: ;
        endcase
        e.z = (e.res == 16'h0000);
        e.n = e.res[15];
        return e;
    endfunction

    function automatic bit updates_carry(input logic [3:0] op);
`ifdef ALU_PIPE_MUL_EN
        if (op == OP_MUL) return 1'b1;
`endif
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP) || (op == OP_ADC) ||
               (op == OP_SBB) || (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
    endfunction

    function automatic int exp_latency(input logic [3:0] op, input logic [15:0] y);
`ifdef ALU_PIPE_MUL_EN
        if (op == OP_MUL) return WIDTH + 1;
`endif
        if (((op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR)) && (y[3:0] != 4'd0))
            return int'(y[3:0]) + 1;
        return 1;
    endfunction

    // Scoreboard: every result the consumer accepts is compared with the oldest expectation.
    always @(negedge clk) begin
        exp_t got;
        exp_t exp;
        if (!rst && out_valid && out_ready) begin
            got = {result, zero, carry, overflow, negative};
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got res=%h with nothing pending", got.res);
            end else begin
                exp = sb_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL result_flags: got res=%h z=%b c=%b v=%b n=%b, expected res=%h z=%b c=%b v=%b n=%b",
                             got.res, got.z, got.c, got.v, got.n, exp.res, exp.z, exp.c, exp.v, exp.n);
                end
            end
        end
    end

    // Enter and leave aligned one time unit after a rising edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        bit   sent;
        exp_t e;
        sent     = 1'b0;
        opcode   = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !sent; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e = model(op, x, y, model_c);
                sb_q.push_back(e);
                if (updates_carry(op)) model_c = e.c;
                sent = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        opcode   = 4'($urandom);
        if (!sent) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: op=%0d never accepted", op);
        end
    endtask

    task automatic wait_out(input int want_lat, input bit chk_ready, input string name);
        int lat;
        bit bad_rdy;
        lat     = 0;
        bad_rdy = 1'b0;
        for (int i = 1; i <= 200 && lat == 0; i++) begin
            @(negedge clk);
            if (out_valid) lat = i;
            else if (in_ready) bad_rdy = 1'b1;
            if (lat == 0) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (lat != want_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, expected %0d", name, lat, want_lat);
        end
        if (chk_ready) begin
            checks++;
            if (bad_rdy) begin
                errors++;
                $display("FAIL %s_busy_ready: in_ready was 1, expected 0 while busy", name);
            end
        end
    endtask

    task automatic drain_wait();
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb_q.size());
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({out_valid, result, zero, carry, overflow, negative} !== 21'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b res=%h flags=%b%b%b%b, expected all 0",
                     out_valid, result, zero, carry, overflow, negative);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got in_ready=%b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        issue(OP_ADD, 16'h7FFF, 16'h0001);
        wait_out(1, 1'b0, "add_ovf");
        issue(OP_ADD, 16'hFFFF, 16'h0001);
        wait_out(1, 1'b0, "add_carry");
        issue(OP_ADC, 16'h0000, 16'h0000);
        wait_out(1, 1'b0, "adc");
    endtask

    task automatic test_shift();
        issue(OP_ASR, 16'h8001, 16'h0004);
        wait_out(exp_latency(OP_ASR, 16'h0004), 1'b1, "asr4");
        issue(OP_SHL, 16'h00F1, 16'h0000);
        wait_out(exp_latency(OP_SHL, 16'h0000), 1'b0, "shl0");
        issue(OP_SHR, 16'h8000, 16'h000F);
        wait_out(exp_latency(OP_SHR, 16'h000F), 1'b1, "shr15");
        issue(OP_SHL, 16'h4001, 16'hFFF3);
        wait_out(exp_latency(OP_SHL, 16'hFFF3), 1'b1, "shl3");
    endtask

    task automatic test_hold();
        exp_t held;
        out_ready = 1'b0;
        issue(OP_SUB, 16'h0003, 16'h0005);
        held = sb_q[sb_q.size() - 1];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {result, zero, carry, overflow, negative} !== held) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%b ready=%b res=%h c=%b, expected valid=1 ready=0 res=%h c=%b",
                         k, out_valid, in_ready, result, carry, held.res, held.c);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_drain_ready: got in_ready=%b, expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got ready=%b valid=%b, expected ready=1 valid=0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_shift();
        bit seen;
        seen = 1'b0;
        issue(OP_ADD, 16'hFFFF, 16'h0001);
        wait_out(1, 1'b0, "pre_rst_add");
        issue(OP_SHL, 16'h1234, 16'h000A);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || carry !== 1'b0 || result !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: got valid=%b carry=%b res=%h, expected 0 0 0000", out_valid, carry, result);
        end
        void'(sb_q.pop_back());
        model_c = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready: got in_ready=%b, expected 1", in_ready);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL aborted_shift: got out_valid=1 after reset, expected none");
        end
        issue(OP_ADC, 16'h0000, 16'h0000);
        wait_out(1, 1'b0, "adc_after_rst");
    endtask

    task automatic test_mul();
        issue(OP_MUL, 16'h0100, 16'h0100);
        wait_out(exp_latency(OP_MUL, 16'h0100), 1'b1, "mul_ovf");
        issue(OP_MUL, 16'h1234, 16'h0003);
        wait_out(exp_latency(OP_MUL, 16'h0003), 1'b0, "mul_small");
        issue(OP_MUL, 16'hFFFF, 16'hFFFF);
        wait_out(exp_latency(OP_MUL, 16'hFFFF), 1'b0, "mul_max");
    endtask

    task automatic test_back_to_back();
        int start;
        logic [3:0]  ops [6] = '{OP_AND, OP_OR, OP_XOR, OP_CMP, OP_SBB, 4'd14};
        logic [15:0] xs  [6] = '{16'hF0F0, 16'h0F00, 16'hAAAA, 16'h8000, 16'h0000, 16'h1234};
        logic [15:0] ys  [6] = '{16'h3C3C, 16'h00F0, 16'hAAAA, 16'h0001, 16'h0000, 16'h5678};
        out_ready = 1'b1;
        start = cyc;
        for (int i = 0; i < 6; i++) issue(ops[i], xs[i], ys[i]);
        checks++;
        if (cyc - start != 6) begin
            errors++;
            $display("FAIL back_to_back: got %0d cycles for 6 requests, expected 6", cyc - start);
        end
        drain_wait();
    endtask

    task automatic test_random();
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++)
            issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
        drain_wait();
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift();
        test_hold();
        test_reset_mid_shift();
        test_mul();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
